// File: rtl/alu_result_capture.sv
// Capture FIFO on the ALU output side: tags each sampled result with a sequence
// number, buffers DEPTH entries for a valid/ready reader and tracks dropped captures.
module alu_result_capture #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          captura_valida,
  input  logic [2:0]    Codigo_OP,
  input  logic [15:0]   Resultado,
  input  logic          banderaA,
  input  logic          banderaB,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [28:0]   rd_dato,
  output logic [AW:0]   cuenta,
  output logic          lleno,
  output logic          vacio,
  output logic          desborde,
  input  logic          borrar_desborde,
  output logic [7:0]    descartes
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR = AW'(1);

  logic [28:0]   mem_q [DEPTH];
  logic [28:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cuenta_q, cuenta_d;
  logic [7:0]    seq_q, seq_d;
  logic          desborde_q, desborde_d;
  logic [7:0]    descartes_q, descartes_d;

  logic          rd_fire;
  logic          wr_en;
  logic          drop;
  logic [28:0]   entry;

  assign vacio     = (cuenta_q == '0);
  assign lleno     = (cuenta_q == FULL_CNT);
  assign rd_valid  = !vacio;
  assign cuenta    = cuenta_q;
  assign desborde  = desborde_q;
  assign descartes = descartes_q;
  assign rd_dato   = vacio ? '0 : mem_q[rd_ptr_q];

  // A read in the same cycle frees a slot, so a full FIFO can still accept.
  assign rd_fire = rd_valid && rd_ready;
  assign wr_en   = captura_valida && (!lleno || rd_fire);
  assign drop    = captura_valida && lleno && !rd_fire;
  assign entry   = {seq_q, Codigo_OP, banderaA, banderaB, Resultado};

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cuenta_d    = cuenta_q;
    seq_d       = seq_q;
    desborde_d  = desborde_q;
    descartes_d = descartes_q;

    if (wr_en) begin
      mem_d[wr_ptr_q] = entry;
      wr_ptr_d        = wr_ptr_q + ONE_PTR;
    end
    if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + ONE_PTR;
    end
    if (wr_en && !rd_fire) begin
      cuenta_d = cuenta_q + ONE_CNT;
    end else if (rd_fire && !wr_en) begin
      cuenta_d = cuenta_q - ONE_CNT;
    end

    // Every strobe consumes a sequence number so the reader can spot gaps.
    if (captura_valida) begin
      seq_d = seq_q + 8'd1;
    end

    if (drop) begin
      desborde_d = 1'b1;
      if (borrar_desborde) begin
        descartes_d = 8'd1;
      end else if (descartes_q != 8'hFF) begin
        descartes_d = descartes_q + 8'd1;
      end
    end else if (borrar_desborde) begin
      desborde_d  = 1'b0;
      descartes_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cuenta_q    <= '0;
      seq_q       <= '0;
      desborde_q  <= 1'b0;
      descartes_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cuenta_q    <= cuenta_d;
      seq_q       <= seq_d;
      desborde_q  <= desborde_d;
      descartes_q <= descartes_d;
    end
  end

  // Storage needs no reset: occupancy gates everything the reader can see.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_alu_result_capture.sv
// Self-checking bench for alu_result_capture: a table of single-cycle vectors
// followed by hand-written multi-cycle sequences (fill, overflow, wrap, reset).
module tb_alu_result_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        captura_valida;
  logic [2:0]  Codigo_OP;
  logic [15:0] Resultado;
  logic        banderaA;
  logic        banderaB;
  logic        rd_valid;
  logic        rd_ready;
  logic [28:0] rd_dato;
  logic [3:0]  cuenta;
  logic        lleno;
  logic        vacio;
  logic        desborde;
  logic        borrar_desborde;
  logic [7:0]  descartes;

  int testsRun = 0;
  int testsFailed = 0;

  alu_result_capture #(.DEPTH(8), .AW(3)) dut (
    .clk(clk),
    .rst(rst),
    .captura_valida(captura_valida),
    .Codigo_OP(Codigo_OP),
    .Resultado(Resultado),
    .banderaA(banderaA),
    .banderaB(banderaB),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .rd_dato(rd_dato),
    .cuenta(cuenta),
    .lleno(lleno),
    .vacio(vacio),
    .desborde(desborde),
    .borrar_desborde(borrar_desborde),
    .descartes(descartes)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cap;
    logic [2:0]  op;
    logic [15:0] res;
    logic        fa;
    logic        fb;
    logic        rdy;
    logic        clr;
    logic        expValid;
    logic [28:0] expDato;
    logic [3:0]  expCuenta;
    logic        expDesborde;
    logic [7:0]  expDescartes;
  } vector_t;

  vector_t vecs [7];

  function automatic logic [28:0] packEntry(input logic [7:0] seq, input logic [2:0] op,
                                            input logic fa, input logic fb, input logic [15:0] res);
    return {seq, op, fa, fb, res};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, step past the rising edge, then release the strobes.
  task automatic applyStimulus(input logic cap, input logic [2:0] op, input logic [15:0] res,
                               input logic fa, input logic fb, input logic rdy, input logic clr);
    captura_valida  = cap;
    Codigo_OP       = op;
    Resultado       = res;
    banderaA        = fa;
    banderaB        = fb;
    rd_ready        = rdy;
    borrar_desborde = clr;
    @(posedge clk);
    #1;
    captura_valida  = 1'b0;
    rd_ready        = 1'b0;
    borrar_desborde = 1'b0;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("reset_vacio", 32'(vacio), 32'd1);
    checkOutput("reset_lleno", 32'(lleno), 32'd0);
    checkOutput("reset_valid", 32'(rd_valid), 32'd0);
    checkOutput("reset_cuenta", 32'(cuenta), 32'd0);
    checkOutput("reset_desborde", 32'(desborde), 32'd0);
    checkOutput("reset_descartes", 32'(descartes), 32'd0);
    checkOutput("reset_dato", 32'(rd_dato), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    captura_valida = 1'b0;
    Codigo_OP = '0;
    Resultado = '0;
    banderaA = 1'b0;
    banderaB = 1'b0;
    rd_ready = 1'b0;
    borrar_desborde = 1'b0;

    //         cap  op    res       fa    fb    rdy   clr   valid dato          cnt   dsb   dsc
    vecs[0] = '{1'b1, 3'd0, 16'h0047, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 29'h0010047, 4'd1, 1'b0, 8'd0};
    vecs[1] = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 29'h0000000, 4'd0, 1'b0, 8'd0};
    vecs[2] = '{1'b1, 3'd5, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 29'h0361234, 4'd1, 1'b0, 8'd0};
    vecs[3] = '{1'b1, 3'd2, 16'hABCD, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 29'h04BABCD, 4'd1, 1'b0, 8'd0};
    vecs[4] = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 29'h0000000, 4'd0, 1'b0, 8'd0};
    vecs[5] = '{1'b1, 3'd7, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 29'h07CFFFF, 4'd1, 1'b0, 8'd0};
    vecs[6] = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 29'h0000000, 4'd0, 1'b0, 8'd0};

    resetDut();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].cap, vecs[i].op, vecs[i].res, vecs[i].fa, vecs[i].fb,
                    vecs[i].rdy, vecs[i].clr);
      checkOutput($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d_dato", i), 32'(rd_dato), 32'(vecs[i].expDato));
      checkOutput($sformatf("vec%0d_cuenta", i), 32'(cuenta), 32'(vecs[i].expCuenta));
      checkOutput($sformatf("vec%0d_desborde", i), 32'(desborde), 32'(vecs[i].expDesborde));
      checkOutput($sformatf("vec%0d_descartes", i), 32'(descartes), 32'(vecs[i].expDescartes));
    end

    // Opcode sweep fills the FIFO, then three extra strobes are dropped.
    resetDut();
    for (int op = 0; op < 8; op++) begin
      applyStimulus(1'b1, 3'(op), 16'(op * 16'h0101), op[0], op[1], 1'b0, 1'b0);
    end
    checkOutput("sweep_lleno", 32'(lleno), 32'd1);
    checkOutput("sweep_cuenta", 32'(cuenta), 32'd8);
    checkOutput("sweep_desborde", 32'(desborde), 32'd0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 3'd6, 16'hDEAD, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    checkOutput("ovf_desborde", 32'(desborde), 32'd1);
    checkOutput("ovf_descartes", 32'(descartes), 32'd3);
    checkOutput("ovf_cuenta", 32'(cuenta), 32'd8);

    // Full FIFO with simultaneous read and write: head is seq 0, new entry is seq 11.
    checkOutput("concur_head", 32'(rd_dato), 32'(packEntry(8'd0, 3'd0, 1'b0, 1'b0, 16'h0000)));
    applyStimulus(1'b1, 3'd3, 16'hBEEF, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("concur_cuenta", 32'(cuenta), 32'd8);
    checkOutput("concur_descartes", 32'(descartes), 32'd3);
    checkOutput("concur_lleno", 32'(lleno), 32'd1);

    for (int s = 1; s < 8; s++) begin
      checkOutput($sformatf("drain_seq%0d", s), 32'(rd_dato),
                  32'(packEntry(8'(s), 3'(s), s[0], s[1], 16'(s * 16'h0101))));
      applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    checkOutput("drain_gap_seq11", 32'(rd_dato), 32'(packEntry(8'd11, 3'd3, 1'b1, 1'b0, 16'hBEEF)));
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("drain_vacio", 32'(vacio), 32'd1);
    checkOutput("drain_desborde_held", 32'(desborde), 32'd1);
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("clear_desborde", 32'(desborde), 32'd0);
    checkOutput("clear_descartes", 32'(descartes), 32'd0);

    // Drop counter saturates; clear together with a drop leaves one drop counted.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 3'd1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int k = 0; k < 260; k++) begin
      applyStimulus(1'b1, 3'd1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("sat_descartes", 32'(descartes), 32'd255);
    applyStimulus(1'b1, 3'd1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("clrdrop_desborde", 32'(desborde), 32'd1);
    checkOutput("clrdrop_descartes", 32'(descartes), 32'd1);

    // Sequence wrap with continuous reads: each entry is read the cycle after capture.
    resetDut();
    for (int i = 0; i < 260; i++) begin
      if (i > 0) begin
        checkOutput($sformatf("wrap_seq%0d", i), 32'(rd_dato[28:21]), 32'((i - 1) % 256));
      end
      applyStimulus(1'b1, 3'd4, 16'(i), 1'b0, 1'b0, 1'b1, 1'b0);
    end
    checkOutput("wrap_last_seq", 32'(rd_dato[28:21]), 32'd3);
    checkOutput("wrap_cuenta", 32'(cuenta), 32'd1);
    checkOutput("wrap_desborde", 32'(desborde), 32'd0);

    // Reset with five stored entries and a simultaneous capture.
    resetDut();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 3'd2, 16'h0F0F, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    checkOutput("mid_cuenta_before", 32'(cuenta), 32'd5);
    rst = 1'b1;
    applyStimulus(1'b1, 3'd2, 16'h0F0F, 1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("mid_vacio", 32'(vacio), 32'd1);
    checkOutput("mid_cuenta", 32'(cuenta), 32'd0);
    checkOutput("mid_valid", 32'(rd_valid), 32'd0);
    applyStimulus(1'b1, 3'd6, 16'h5A5A, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("mid_first_seq0", 32'(rd_dato), 32'(packEntry(8'd0, 3'd6, 1'b1, 1'b0, 16'h5A5A)));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
